uart_cmd_decoder: RTL and testbench

- Host-to-FPGA end of the UART control protocol. The PC sends framed configuration commands; this block parses them from the uart_receive byte stream.
- Validates each frame, then updates the ultrasound configuration registers: used channels, A-line count, pulse shape and per-channel delays.
- Issues a start strobe toward image_transmit_fsm.
- Sits between uart_receive and the image/pulse logic in main.

---
 rtl/uart_cmd_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Parses framed configuration commands from the UART byte stream and
// updates the ultrasound configuration registers on a valid frame.
module uart_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         MAX_LEN        = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   received_data,
    input  logic         new_received_data,
    output logic [7:0]   used_channels,
    output logic [4:0]   num_alines,
    output logic [31:0]  pulse_shape,
    output logic [127:0] delays,
    output logic         start_us,
    output logic         cmd_valid,
    output logic         cmd_error,
    output logic [2:0]   err_code,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK
    } state_t;

    localparam int GW = $clog2(TIMEOUT_CYCLES);
    localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);

    state_t         state_q, state_d;
    logic           nrd_q, nrd_d;
    logic           stb_q, stb_d;
    logic [7:0]     byte_q, byte_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [7:0]     len_q, len_d;
    logic [7:0]     chk_q, chk_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     buf_q [MAX_LEN];
    logic [7:0]     buf_d [MAX_LEN];
    logic [GW-1:0]  gap_q, gap_d;
    logic [7:0]     used_q, used_d;
    logic [4:0]     alines_q, alines_d;
    logic [31:0]    pulse_q, pulse_d;
    logic [127:0]   delays_q, delays_d;
    logic           start_q, start_d;
    logic           valid_q, valid_d;
    logic           error_q, error_d;
    logic [2:0]     ecode_q, ecode_d;
    logic           range_bad;

    function automatic logic [7:0] exp_len(input logic [7:0] c);
        case (c)
            8'h01:   exp_len = 8'd1;
            8'h02:   exp_len = 8'd1;
            8'h03:   exp_len = 8'd4;
            8'h04:   exp_len = 8'd3;
            default: exp_len = 8'd0;
        endcase
    endfunction

    assign range_bad =
        (cmd_q == 8'h02 && (buf_q[0] == 8'h00 || buf_q[0] > 8'd31)) ||
        (cmd_q == 8'h04 && buf_q[0] > 8'd7);

    always_comb begin
        state_d  = state_q;
        nrd_d    = new_received_data;
        stb_d    = new_received_data & ~nrd_q;
        byte_d   = received_data;
        cmd_d    = cmd_q;
        len_d    = len_q;
        chk_d    = chk_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        gap_d    = gap_q;
        used_d   = used_q;
        alines_d = alines_q;
        pulse_d  = pulse_q;
        delays_d = delays_q;
        ecode_d  = ecode_q;
        start_d  = 1'b0;
        valid_d  = 1'b0;
        error_d  = 1'b0;

        // Inter-byte gap watchdog; any accepted byte restarts it.
        if (state_q != S_IDLE) begin
            if (stb_q) begin
                gap_d = '0;
            end else if (gap_q == GAP_MAX) begin
                state_d = S_IDLE;
                error_d = 1'b1;
                ecode_d = 3'd4;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end

        if (stb_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (byte_q == SYNC_BYTE) begin
                        state_d = S_CMD;
                        gap_d   = '0;
                    end
                end
                S_CMD: begin
                    if (byte_q >= 8'h01 && byte_q <= 8'h05) begin
                        cmd_d   = byte_q;
                        chk_d   = byte_q;
                        state_d = S_LEN;
                    end else begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                        ecode_d = 3'd1;
                    end
                end
                S_LEN: begin
                    if (byte_q == exp_len(cmd_q)) begin
                        len_d   = byte_q;
                        chk_d   = chk_q ^ byte_q;
                        cnt_d   = '0;
                        state_d = (byte_q == 8'd0) ? S_CHK : S_PAYLOAD;
                    end else begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                        ecode_d = 3'd2;
                    end
                end
                S_PAYLOAD: begin
                    buf_d[cnt_q] = byte_q;
                    chk_d        = chk_q ^ byte_q;
                    cnt_d        = cnt_q + CW'(1);
                    if ({{(8-CW){1'b0}}, cnt_q} == len_q - 8'd1) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    state_d = S_IDLE;
                    if (byte_q != chk_q) begin
                        error_d = 1'b1;
                        ecode_d = 3'd3;
                    end else if (range_bad) begin
                        error_d = 1'b1;
                        ecode_d = 3'd5;
                    end else begin
                        valid_d = 1'b1;
                        case (cmd_q)
                            8'h01: used_d   = buf_q[0];
                            8'h02: alines_d = buf_q[0][4:0];
                            8'h03: pulse_d  = {buf_q[0], buf_q[1],
                                               buf_q[2], buf_q[3]};
                            8'h04: delays_d[{buf_q[0][2:0], 4'b0000} +: 16] =
                                       {buf_q[1], buf_q[2]};
                            default: start_d = 1'b1;
                        endcase
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            nrd_q    <= 1'b0;
            stb_q    <= 1'b0;
            byte_q   <= '0;
            cmd_q    <= '0;
            len_q    <= '0;
            chk_q    <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
            used_q   <= '0;
            alines_q <= '0;
            pulse_q  <= '0;
            delays_q <= '0;
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            ecode_q  <= '0;
        end else begin
            state_q  <= state_d;
            nrd_q    <= nrd_d;
            stb_q    <= stb_d;
            byte_q   <= byte_d;
            cmd_q    <= cmd_d;
            len_q    <= len_d;
            chk_q    <= chk_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            buf_q    <= buf_d;
            used_q   <= used_d;
            alines_q <= alines_d;
            pulse_q  <= pulse_d;
            delays_q <= delays_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            ecode_q  <= ecode_d;
        end
    end

    assign used_channels = used_q;
    assign num_alines    = alines_q;
    assign pulse_shape   = pulse_q;
    assign delays        = delays_q;
    assign start_us      = start_q;
    assign cmd_valid     = valid_q;
    assign cmd_error     = error_q;
    assign err_code      = ecode_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Frame-level reference model of the command decoder, checked every cycle,
// plus directed frames with literal expectations.
module tb_uart_cmd_decoder;

    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rxd = 8'h00;
    logic         nrd = 1'b0;
    logic [7:0]   used_channels;
    logic [4:0]   num_alines;
    logic [31:0]  pulse_shape;
    logic [127:0] delays;
    logic         start_us, cmd_valid, cmd_error, busy;
    logic [2:0]   err_code;

    uart_cmd_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .MAX_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .received_data(rxd), .new_received_data(nrd),
        .used_channels(used_channels), .num_alines(num_alines),
        .pulse_shape(pulse_shape), .delays(delays),
        .start_us(start_us), .cmd_valid(cmd_valid), .cmd_error(cmd_error),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int n_valid = 0, n_error = 0, n_start = 0;
    bit chk_on = 0;
    int cyc = 0;

    // Reference model state
    logic [7:0]   m_used = 0;
    logic [4:0]   m_na = 0;
    logic [31:0]  m_pulse = 0;
    logic [127:0] m_delays = 0;
    logic         m_valid = 0, m_error = 0, m_start = 0;
    logic [2:0]   m_ec = 0;
    bit           m_in = 0, m_pend = 0, m_prev = 0;
    logic [7:0]   m_pbyte = 0;
    int           m_gap = 0;
    logic [7:0]   fq[$];

    logic [7:0]   tx[$];

    function automatic int req_len(input logic [7:0] c);
        case (c)
            8'h01: return 1;
            8'h02: return 1;
            8'h03: return 4;
            8'h04: return 3;
            8'h05: return 0;
            default: return -1;
        endcase
    endfunction

    task automatic m_fail(input int code);
        m_error = 1;
        m_ec = 3'(code);
        m_in = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        logic [7:0] x;
        if (!m_in) begin
            if (b == 8'hA5) begin
                m_in = 1;
                fq.delete();
                m_gap = 0;
            end
        end else begin
            fq.push_back(b);
            m_gap = 0;
            n = fq.size();
            if (n == 1) begin
                if (req_len(b) < 0) m_fail(1);
            end else if (n == 2) begin
                if (int'(b) != req_len(fq[0])) m_fail(2);
            end else if (n == int'(fq[1]) + 3) begin
                x = 0;
                for (int i = 0; i < n - 1; i++) x ^= fq[i];
                if (x != b) m_fail(3);
                else if ((fq[0] == 2 && (fq[2] == 0 || fq[2] > 31)) ||
                         (fq[0] == 4 && fq[2] > 7)) m_fail(5);
                else begin
                    m_valid = 1;
                    m_in = 0;
                    case (fq[0])
                        8'h01: m_used = fq[2];
                        8'h02: m_na = fq[2][4:0];
                        8'h03: m_pulse = {fq[2], fq[3], fq[4], fq[5]};
                        8'h04: m_delays[int'(fq[2]) * 16 +: 16] = {fq[3], fq[4]};
                        default: m_start = 1;
                    endcase
                end
            end
        end
    endtask

    always @(posedge clk) begin
        m_valid = 0;
        m_error = 0;
        m_start = 0;
        if (rst) begin
            m_used = 0; m_na = 0; m_pulse = 0; m_delays = 0; m_ec = 0;
            m_in = 0; m_pend = 0; m_prev = 0; m_gap = 0;
            fq.delete();
        end else begin
            if (m_pend) model_byte(m_pbyte);
            else if (m_in) begin
                if (m_gap == TO - 1) m_fail(4);
                else m_gap++;
            end
            m_pend = nrd && !m_prev;
            m_pbyte = rxd;
            m_prev = nrd;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (chk_on) begin
            if (cmd_valid === 1'b1) n_valid++;
            if (cmd_error === 1'b1) n_error++;
            if (start_us === 1'b1) n_start++;
            vectors++;
            if ({used_channels, num_alines, pulse_shape, delays, start_us,
                 cmd_valid, cmd_error, err_code, busy} !==
                {m_used, m_na, m_pulse, m_delays, m_start,
                 m_valid, m_error, m_ec, m_in}) begin
                miscompares++;
                $display("FAIL cycle %0d: dut ch=%h na=%0d ps=%h dl=%h st/v/e/ec/b=%b%b%b%0d%b model ch=%h na=%0d ps=%h dl=%h st/v/e/ec/b=%b%b%b%0d%b",
                    cyc, used_channels, num_alines, pulse_shape, delays,
                    start_us, cmd_valid, cmd_error, err_code, busy,
                    m_used, m_na, m_pulse, m_delays,
                    m_start, m_valid, m_error, m_ec, m_in);
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rxd = b;
        nrd = 1'b1;
        repeat (2) @(posedge clk);
        #1 nrd = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_tx(input int n);
        for (int i = 0; i < n && i < tx.size(); i++)
            send_byte(tx[i], $urandom_range(0, 3));
    endtask

    task automatic push_chk();
        logic [7:0] x = 0;
        for (int i = 1; i < tx.size(); i++) x ^= tx[i];
        tx.push_back(x);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic build(input int c, input int kind);
        tx.delete();
        tx.push_back(8'hA5);
        tx.push_back(8'(c));
        tx.push_back(8'(req_len(8'(c))));
        case (c)
            1: tx.push_back(8'($urandom));
            2: tx.push_back(8'($urandom_range(1, 31)));
            3: repeat (4) tx.push_back(8'($urandom));
            4: begin
                tx.push_back(8'($urandom_range(0, 7)));
                tx.push_back(8'($urandom));
                tx.push_back(8'($urandom));
            end
            default: ;
        endcase
        if (kind == 3) tx[2] = tx[2] + 8'($urandom_range(1, 7));
        if (kind == 4 && c == 2)
            tx[3] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(32, 255));
        if (kind == 4 && c == 4) tx[3] = 8'($urandom_range(8, 255));
        push_chk();
        if (kind == 1) tx[tx.size()-1] ^= 8'($urandom_range(1, 255));
    endtask

    int v0, e0, s0;
    logic [7:0] nb;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1;
        @(posedge clk); #1;
        check("reset_used", {120'b0, used_channels}, 128'h0);
        check("reset_delays", delays, 128'h0);
        check("reset_busy_err", {124'b0, busy, err_code}, 128'h0);

        v0 = n_valid; e0 = n_error;
        tx = '{8'hA5, 8'h01, 8'h01, 8'h0F};
        push_chk();
        send_tx(tx.size()); settle();
        check("set_channels", {120'b0, used_channels}, 128'h0F);
        check("model_channels", {120'b0, m_used}, 128'h0F);
        check("set_ch_valid", 128'(n_valid - v0), 128'd1);
        check("set_ch_noerr", 128'(n_error - e0), 128'd0);

        pulse_rst();
        e0 = n_error;
        tx = '{8'hA5, 8'h01, 8'h01, 8'h0F, 8'h0E};
        send_tx(tx.size()); settle();
        check("badchk_code", {125'b0, err_code}, 128'd3);
        check("badchk_pulse", 128'(n_error - e0), 128'd1);
        check("badchk_used", {120'b0, used_channels}, 128'h00);

        tx = '{8'hA5, 8'h04, 8'h03, 8'h03, 8'h12, 8'h34};
        push_chk();
        send_tx(tx.size()); settle();
        check("delay_set", delays, {64'b0, 16'h1234, 48'b0});
        check("model_delay", m_delays, {64'b0, 16'h1234, 48'b0});
        tx = '{8'hA5, 8'h04, 8'h03, 8'h09, 8'h00, 8'h01};
        push_chk();
        send_tx(tx.size()); settle();
        check("delay_range_code", {125'b0, err_code}, 128'd5);
        check("delay_unchanged", delays, {64'b0, 16'h1234, 48'b0});

        tx = '{8'hA5, 8'h02, 8'h01, 8'h10};
        push_chk();
        send_tx(tx.size()); settle();
        check("alines16", {123'b0, num_alines}, 128'd16);
        s0 = n_start;
        tx = '{8'hA5, 8'h05, 8'h00, 8'h05};
        send_tx(tx.size()); settle();
        check("start_once", 128'(n_start - s0), 128'd1);
        tx = '{8'hA5, 8'h02, 8'h01, 8'h00};
        push_chk();
        send_tx(tx.size()); settle();
        check("alines0_code", {125'b0, err_code}, 128'd5);
        check("alines_kept", {123'b0, num_alines}, 128'd16);

        e0 = n_error;
        tx = '{8'hA5, 8'h01};
        send_tx(tx.size());
        repeat (TO + 8) @(posedge clk);
        #1;
        check("timeout_code", {125'b0, err_code}, 128'd4);
        check("timeout_pulse", 128'(n_error - e0), 128'd1);
        check("timeout_busy", {127'b0, busy}, 128'd0);
        tx = '{8'hA5, 8'h03, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        push_chk();
        send_tx(tx.size()); settle();
        check("pulse_shape", {96'b0, pulse_shape}, 128'hDEADBEEF);

        v0 = n_valid; e0 = n_error;
        tx = '{8'hA5, 8'h01, 8'h01};
        send_tx(tx.size());
        pulse_rst();
        tx = '{8'h0F, 8'h0F};
        send_tx(tx.size()); settle();
        check("rstmid_events", 128'((n_valid - v0) + (n_error - e0)), 128'd0);
        check("rstmid_outs", {busy, err_code, used_channels, num_alines,
                              pulse_shape, 79'b0} | delays, 128'd0);
        tx = '{8'hA5, 8'h07};
        send_tx(tx.size()); settle();
        check("unknown_cmd", {125'b0, err_code}, 128'd1);
        tx = '{8'hA5, 8'h01, 8'h02};
        send_tx(tx.size()); settle();
        check("wrong_len", {125'b0, err_code}, 128'd2);

        for (int f = 0; f < 200; f++) begin
            int kind = $urandom_range(0, 9);
            int c = $urandom_range(1, 5);
            if (kind == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    nb = 8'($urandom);
                    if (nb == 8'hA5) nb = 8'h00;
                    send_byte(nb, $urandom_range(0, 3));
                end
            end
            build(c, kind);
            if (kind == 2) begin
                nb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(6, 255));
                tx = '{8'hA5, nb};
                send_tx(tx.size());
            end else if (kind == 5) begin
                send_tx($urandom_range(1, tx.size() - 1));
                repeat (TO + 10) @(posedge clk);
            end else if (kind == 6) begin
                send_tx($urandom_range(1, tx.size() - 1));
                pulse_rst();
            end else begin
                send_tx(tx.size());
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (10) @(posedge clk);
        #1 chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
